// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the 32-bit word, the 2-bit direction counter encoding and
// the branch target buffer entry layout used by the branch predictor.
// Contents: word_t, cnt2_t + CNT_* constants, btb_entry_t, pc_tag() helper.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [1:0]  cnt2_t;

   localparam cnt2_t CNT_SNT = 2'b00;   // strong not-taken
   localparam cnt2_t CNT_WNT = 2'b01;   // weak not-taken
   localparam cnt2_t CNT_WT  = 2'b10;   // weak taken
   localparam cnt2_t CNT_ST  = 2'b11;   // strong taken

   // Smallest table (4 entries) leaves 28 tag bits; larger tables zero-fill
   // the unused upper tag bits, so one struct fits every table size.
   localparam int TAG_MAX_W = 28;

   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
      word_t                target;
      cnt2_t                cnt;
   } btb_entry_t;

   // Tag is everything above the index and the ignored byte offset.
   function automatic logic [TAG_MAX_W-1:0] pc_tag(input word_t pc, input int idx_w);
      return TAG_MAX_W'(pc >> (idx_w + 2));
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating up/down counter, next-state only (purely combinational).
// Ports: cnt_i current value, up_i 1=increment 0=decrement, cnt_o next value.
// Saturates at CNT_ST going up and CNT_SNT going down.
module sat_counter2
   import cpu_types_pkg::*;
(
   input  cnt2_t cnt_i,
   input  logic  up_i,
   output cnt2_t cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      if (up_i) begin
         if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
      end else begin
         if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and resolve-stage
// mispredict detection. Lookup and mispredict are zero-latency combinational;
// table and statistics update on CLK when upd_en (stall) permits.
// Ports: if_pc lookup -> pred_hit/pred_taken/pred_target; upd_* resolve bus ->
// mispredict/correct_pc; clear invalidates all entries; stat_* event counters.
module branch_predictor
   import cpu_types_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  word_t            if_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output word_t            pred_target,
   input  logic             upd_en,
   input  logic             upd_valid,
   input  word_t            upd_pc,
   input  logic             upd_taken,
   input  word_t            upd_target,
   input  logic             upd_pred_taken,
   input  word_t            upd_pred_target,
   output logic             mispredict,
   output word_t            correct_pc,
   input  logic             clear,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [CNT_W-1:0] STAT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef logic [IDX_W-1:0] idx_t;

   btb_entry_t           tbl_q [ENTRIES];

   idx_t                 if_idx;
   idx_t                 upd_idx;
   logic [TAG_MAX_W-1:0] if_tag;
   logic [TAG_MAX_W-1:0] upd_tag;
   btb_entry_t           if_ent;
   btb_entry_t           upd_ent;
   btb_entry_t           upd_ent_d;
   logic                 upd_hit;
   logic                 upd_do;
   logic                 tbl_we;
   cnt2_t                cnt_step;
   logic [CNT_W-1:0]     stat_br_q;
   logic [CNT_W-1:0]     stat_br_d;
   logic [CNT_W-1:0]     stat_mp_q;
   logic [CNT_W-1:0]     stat_mp_d;

   // ---------------- lookup (reads registered table: pre-update view) ----
   assign if_idx      = if_pc[IDX_W+1:2];
   assign if_tag      = pc_tag(if_pc, IDX_W);
   assign if_ent      = tbl_q[if_idx];
   assign pred_hit    = if_ent.valid && (if_ent.tag == if_tag);
   assign pred_taken  = pred_hit && if_ent.cnt[1];
   assign pred_target = pred_taken ? if_ent.target : if_pc + 32'd4;

   // ---------------- resolve ----------------------------------------------
   // A taken branch with a wrong target is a mispredict even if direction
   // was right; a correctly predicted not-taken branch has no target to check.
   assign mispredict = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
   assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;

   // ---------------- update -----------------------------------------------
   // clear takes priority and drops any update issued in the same cycle.
   assign upd_do  = upd_en && upd_valid && !clear;
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = pc_tag(upd_pc, IDX_W);
   assign upd_ent = tbl_q[upd_idx];
   assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

   sat_counter2 u_cnt (
      .cnt_i (upd_ent.cnt),
      .up_i  (upd_taken),
      .cnt_o (cnt_step)
   );

   always_comb begin
      upd_ent_d = upd_ent;
      tbl_we    = 1'b0;
      if (upd_do) begin
         if (upd_hit) begin
            tbl_we        = 1'b1;
            upd_ent_d.cnt = cnt_step;
            if (upd_taken) upd_ent_d.target = upd_target;
         end else if (upd_taken) begin
            // Miss + taken: replace whatever occupies the slot, start weak-taken.
            tbl_we    = 1'b1;
            upd_ent_d = '{valid: 1'b1, tag: upd_tag, target: upd_target, cnt: CNT_WT};
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++)
            tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};
      end else if (clear) begin
         for (int i = 0; i < ENTRIES; i++)
            tbl_q[i].valid <= 1'b0;
      end else if (tbl_we) begin
         tbl_q[upd_idx] <= upd_ent_d;
      end
   end

   // ---------------- statistics (saturating) -------------------------------
   always_comb begin
      stat_br_d = stat_br_q;
      stat_mp_d = stat_mp_q;
      if (upd_do) begin
         if (stat_br_q != '1)               stat_br_d = stat_br_q + STAT_ONE;
         if (mispredict && stat_mp_q != '1) stat_mp_d = stat_mp_q + STAT_ONE;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         stat_br_q <= stat_br_d;
         stat_mp_q <= stat_mp_d;
      end
   end

   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mp_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of BTB entries (power of 2, 4..256).
REQ-002 Parameter CNT_W, default 32, width of statistics counters.
REQ-003 CLK  input  1  clock, all state updates on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 if_pc  input  32  fetch-stage PC to look up.
REQ-006 pred_hit  output  1  valid entry with matching tag exists for if_pc.
REQ-007 pred_taken  output  1  predicted direction for if_pc.
REQ-008 pred_target  output  32  predicted next PC for if_pc.
REQ-009 upd_en  input  1  pipeline advancing (not stalled); gates every state change except clear.
REQ-010 upd_valid  input  1  a branch/jump resolved in EX this cycle.
REQ-011 upd_pc  input  32  PC of the resolved instruction.
REQ-012 upd_taken  input  1  actual direction.
REQ-013 upd_target  input  32  actual taken target.
REQ-014 upd_pred_taken  input  1  prediction carried down the pipe with the instruction.
REQ-015 upd_pred_target  input  32  predicted target carried with the instruction.
REQ-016 mispredict  output  1  flush request for IF/ID.
REQ-017 correct_pc  output  32  PC to load on mispredict.
REQ-018 clear  input  1  synchronous invalidate of all entries.
REQ-019 stat_branches  output  CNT_W  resolved branches counted.
REQ-020 stat_mispredicts  output  CNT_W  mispredicts counted.

Function
REQ-021 Index = pc[IDX_W+1:2], IDX_W = log2(ENTRIES); tag = pc[31:IDX_W+2]; pc[1:0] ignored.
REQ-022 Entry = valid, tag, 32-bit target, 2-bit saturating counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-023 Lookup combinational, zero latency: pred_hit = valid && tag match; pred_taken = pred_hit && counter[1]; pred_target = pred_taken ? stored target : if_pc+4.
REQ-024 mispredict combinational = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)); 0 when upd_valid=0.
REQ-025 correct_pc = upd_taken ? upd_target : upd_pc+4 (32-bit wrap).
REQ-026 Update at edge when upd_en && upd_valid && !clear:
  - tag hit, taken: counter+1 saturating at 11, target <= upd_target.
  - tag hit, not taken: counter-1 saturating at 00, target unchanged.
  - miss, taken: allocate/replace entry: valid=1, tag, target, counter=10.
  - miss, not taken: no change.
REQ-027 Lookup and update to same index in same cycle: lookup returns pre-update contents.
REQ-028 clear=1: all valid bits cleared next edge regardless of upd_en; pending update dropped; statistics unaffected.
REQ-029 Statistics: when upd_en && upd_valid, stat_branches+1; additionally stat_mispredicts+1 if mispredict; both saturate at all-ones, never wrap.
REQ-030 upd_en=0: no table or statistic change; mispredict/correct_pc still driven combinationally.

Reset
REQ-031 On nRST low: all valid bits 0, counters 01, targets and tags 0, statistics 0, immediately and independent of CLK.
REQ-032 After reset outputs: pred_hit=0, pred_taken=0, pred_target=if_pc+4; mispredict follows inputs.
REQ-033 Reset asserted mid-update: update discarded, reset values win.

Structure
REQ-034 cpu_types_pkg SHALL hold btb_entry_t struct (valid, tag, target, cnt) and 2-bit counter encoding constants; word_t reused for all 32-bit ports.
REQ-035 One sub-module natural: sat_counter2 (2-bit saturating up/down counter, combinational next-state); table storage in flops, no SRAM macro.

Verification
REQ-036 Reset, if_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44, stats 0.
REQ-037 Update pc=0x40 taken target=0x100 (pred NT) -> mispredict=1, correct_pc=0x100; next cycle lookup 0x40 -> hit, taken, 0x100, counter 10.
REQ-038 Three more taken updates then four not-taken at 0x40 -> counter 11 saturates, then 11->10->01->00->00; pred_taken=0 after second NT.
REQ-039 ENTRIES=16, entry at 0x40, update taken at 0x440 (same index, different tag) -> 0x40 now misses, 0x440 hits with new target.
REQ-040 Update with upd_en=0 -> no table/stat change; clear with simultaneous update -> all entries invalid, update dropped, stats unchanged.
REQ-041 CNT_W=4, 20 mispredicting updates -> both stats hold 0xF.
